// File: rtl/ntt_bram_arbiter_pkg.sv
// Shared types and constants for the NTT BRAM arbiter: FSM states, requester id and the
// word-to-byte address shift applied on the BRAM port.
package ntt_bram_arbiter_pkg;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } arb_state_e;

  // Requester 0 is the x/w loader, requester 1 the y writeback.
  typedef logic req_id_t;

  localparam int unsigned AddrShift = 2;

  function automatic logic [1:0] id_to_onehot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ntt_rd_tag_pipe.sv
// Read-return tracker: a READ_LAT-deep shift register of {valid, requester id} that lines each
// issued read up with the cycle its BRAM data appears.
module ntt_rd_tag_pipe
  import ntt_bram_arbiter_pkg::*;
#(
  parameter int unsigned READ_LAT = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid_i,
  input  req_id_t in_id_i,
  output logic    out_valid_o,
  output req_id_t out_id_o,
  output logic    any_valid_o
);

  logic    [READ_LAT-1:0] vld_q;
  req_id_t [READ_LAT-1:0] id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      id_q[0]  <= in_id_i;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[READ_LAT-1];
  assign out_id_o    = id_q[READ_LAT-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/ntt_bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM: round-robin grants with burst locks,
// a registered BRAM command stage and pipelined read-data return to the issuing requester.
module ntt_bram_arbiter
  import ntt_bram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned READ_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [1:0]        lock_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W+2:0] BRAM_addr,
  output logic [DATA_W-1:0] BRAM_din,
  output logic              BRAM_we,
  output logic              BRAM_en,
  output logic              BRAM_clk,
  input  logic [DATA_W-1:0] BRAM_dout,
  output logic              busy_o
);

  localparam int unsigned BramAw = ADDR_W + 3;

  arb_state_e  state_q, state_d;
  req_id_t     last_q, last_d;
  logic [1:0]  gnt;
  logic        accept;
  req_id_t     acc_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic        rd_issue_q;
  req_id_t     rd_id_q;
  logic        ret_valid;
  req_id_t     ret_id;
  logic        pipe_busy;

  assign BRAM_clk = clk;

  // Grant decode; a lock owner is served only when it actually requests.
  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      StArb: begin
        if (req_i == 2'b11) begin
          gnt = last_q ? 2'b01 : 2'b10;
        end else begin
          gnt = req_i;
        end
      end
      StLock0: gnt = {1'b0, req_i[0]};
      StLock1: gnt = {req_i[1], 1'b0};
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_o     = rst ? gnt : 2'b00;
  assign accept    = |gnt;
  assign acc_id    = gnt[1];
  assign sel_addr  = acc_id ? addr1_i : addr0_i;
  assign sel_wdata = acc_id ? wdata1_i : wdata0_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (accept) begin
      last_d = acc_id;
    end
    unique case (state_q)
      StArb: begin
        if (accept && lock_i[acc_id]) begin
          state_d = acc_id ? StLock1 : StLock0;
        end
      end
      StLock0: if (!lock_i[0]) state_d = StArb;
      StLock1: if (!lock_i[1]) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StArb;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // BRAM command stage; address and data only move on an accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BRAM_en    <= 1'b0;
      BRAM_we    <= 1'b0;
      BRAM_addr  <= '0;
      BRAM_din   <= '0;
      rd_issue_q <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      BRAM_en    <= accept;
      BRAM_we    <= accept & we_i[acc_id];
      rd_issue_q <= accept & ~we_i[acc_id];
      rd_id_q    <= acc_id;
      if (accept) begin
        BRAM_addr <= BramAw'(sel_addr) << AddrShift;
        BRAM_din  <= sel_wdata;
      end
    end
  end

  ntt_rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_issue_q),
    .in_id_i     (rd_id_q),
    .out_valid_o (ret_valid),
    .out_id_o    (ret_id),
    .any_valid_o (pipe_busy)
  );

  assign rvalid_o = ret_valid ? id_to_onehot(ret_id) : 2'b00;
  assign rdata_o  = ret_valid ? BRAM_dout : '0;
  assign busy_o   = (state_q != StArb) | rd_issue_q | pipe_busy;

  gnt_onehot_a : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_o));
  rvalid_onehot_a : assert property (@(posedge clk) disable iff (!rst) $onehot0(rvalid_o));

endmodule

// File: tb/tb_ntt_bram_arbiter.sv
// Self-checking bench for ntt_bram_arbiter: directed scenarios plus randomized traffic compared
// against a transaction-level model of grants, BRAM commands and read returns.
module tb_ntt_bram_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned RL = 3;
  localparam int unsigned Words = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_i = '0, we_i = '0, lock_i = '0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, BRAM_din, BRAM_dout;
  logic [AW+2:0] BRAM_addr;
  logic          BRAM_we, BRAM_en, BRAM_clk, busy_o;

  always #5 clk = ~clk;

  ntt_bram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .lock_i    (lock_i),
    .addr0_i   (addr0_i),
    .addr1_i   (addr1_i),
    .wdata0_i  (wdata0_i),
    .wdata1_i  (wdata1_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .BRAM_addr (BRAM_addr),
    .BRAM_din  (BRAM_din),
    .BRAM_we   (BRAM_we),
    .BRAM_en   (BRAM_en),
    .BRAM_clk  (BRAM_clk),
    .BRAM_dout (BRAM_dout),
    .busy_o    (busy_o)
  );

  // BRAM with RL cycles from registered address to dout; junk when not enabled.
  logic [DW-1:0] bram_mem [Words];
  logic [DW-1:0] bram_dly [RL];
  assign BRAM_dout = bram_dly[RL-1];
  always @(posedge BRAM_clk) begin
    if (BRAM_en && BRAM_we) bram_mem[BRAM_addr[AW+1:2]] <= BRAM_din;
    bram_dly[0] <= BRAM_en ? bram_mem[BRAM_addr[AW+1:2]] : {$urandom, $urandom};
    for (int i = 1; i < RL; i++) bram_dly[i] <= bram_dly[i-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: owner of the lock (-1 = none), last granted, memory shadow, return schedule.
  logic [DW-1:0] m_mem [Words];
  int            m_owner = -1;
  int            m_last = 1;
  int            ret_id [int];
  logic [DW-1:0] ret_data [int];
  logic          n_en = 1'b0, n_we = 1'b0;
  logic [AW+2:0] n_addr = '0;
  logic [DW-1:0] n_din = '0;
  logic [1:0]    e_gnt, e_rv;
  logic [DW-1:0] e_rdata, e_din;
  logic          e_busy, e_en, e_we;
  logic [AW+2:0] e_addr;

  int n_checks = 0;
  int n_fail = 0;

  task automatic reset_model();
    m_owner = -1;
    m_last  = 1;
    ret_id.delete();
    ret_data.delete();
    n_en = 1'b0;
    n_we = 1'b0;
  endtask

  // Evaluates the current cycle at the falling edge and advances the model past the next edge.
  task automatic model_step();
    int g;
    int own;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    e_en = n_en; e_we = n_we; e_addr = n_addr; e_din = n_din;
    own = m_owner;
    e_busy = (own >= 0);
    for (int k = cyc; k <= cyc + int'(RL); k++) if (ret_id.exists(k)) e_busy = 1'b1;
    e_rv    = ret_id.exists(cyc) ? 2'(1 << ret_id[cyc]) : 2'b00;
    e_rdata = ret_id.exists(cyc) ? ret_data[cyc] : '0;
    g = -1;
    if (own >= 0) begin
      if (req_i[own]) g = own;
    end else if (req_i == 2'b11) g = 1 - m_last;
    else if (req_i[0]) g = 0;
    else if (req_i[1]) g = 1;
    e_gnt = (g < 0) ? 2'b00 : 2'(1 << g);
    n_en = (g >= 0);
    n_we = 1'b0;
    if (g >= 0) begin
      a = (g == 1) ? addr1_i : addr0_i;
      d = (g == 1) ? wdata1_i : wdata0_i;
      m_last = g;
      n_we   = we_i[g];
      n_addr = {1'b0, a, 2'b00};
      n_din  = d;
      if (we_i[g]) m_mem[a] = d;
      else begin
        ret_id[cyc+1+int'(RL)]   = g;
        ret_data[cyc+1+int'(RL)] = m_mem[a];
      end
    end
    if (own >= 0) begin
      if (!lock_i[own]) m_owner = -1;
    end else if (g >= 0 && lock_i[g]) m_owner = g;
    if (ret_id.exists(cyc)) begin
      ret_id.delete(cyc);
      ret_data.delete(cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; req_i = '0; we_i = '0; lock_i = '0;
    repeat (2) @(posedge clk);
    reset_model();
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    req_i = 2'b11; we_i = 2'b01; lock_i = 2'b11; addr0_i = 10'd9; wdata0_i = 64'hdead;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
      n_checks++; if (rvalid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", rvalid_o); end
      n_checks++; if (rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
      n_checks++; if ({BRAM_en, BRAM_we} !== 2'b00) begin n_fail++; $display("FAIL reset_en_we got=%b exp=00", {BRAM_en, BRAM_we}); end
      n_checks++; if (BRAM_addr !== '0 || BRAM_din !== '0) begin n_fail++; $display("FAIL reset_addr_din got=%h/%h exp=0/0", BRAM_addr, BRAM_din); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    req_i = 2'b01; we_i = 2'b00; addr0_i = 10'd5;
    for (int t = 0; t <= 5; t++) begin
      model_step();
      if (t == 0) begin
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", gnt_o); end
      end
      if (t == 1) begin
        n_checks++;
        if (BRAM_addr !== 13'd20 || BRAM_we !== 1'b0 || BRAM_en !== 1'b1) begin
          n_fail++; $display("FAIL single_cmd got=addr %0d we %b en %b exp=addr 20 we 0 en 1", BRAM_addr, BRAM_we, BRAM_en);
        end
      end
      n_checks++;
      if (rvalid_o !== ((t == 4) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL single_rvalid t=%0d got=%b", t, rvalid_o);
      end
      if (t == 4) begin
        n_checks++; if (rdata_o !== m_mem[5]) begin n_fail++; $display("FAIL single_rdata got=%h exp=%h", rdata_o, m_mem[5]); end
      end
      next_cycle();
      req_i = 2'b00;
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    req_i = 2'b11; we_i = 2'b00; lock_i = 2'b00;
    for (int t = 0; t < 6 + int'(RL) + 2; t++) begin
      addr0_i = AW'(t + 100); addr1_i = AW'(t + 200);
      if (t >= 6) req_i = 2'b00;
      model_step();
      if (t < 6) begin
        n_checks++;
        if (gnt_o !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_gnt t=%0d got=%b", t, gnt_o); end
      end
      n_checks++;
      if (rvalid_o !== e_rv || (e_rv != 0 && rdata_o !== e_rdata)) begin
        n_fail++; $display("FAIL alt_return t=%0d got=%b/%h exp=%b/%h", t, rvalid_o, rdata_o, e_rv, e_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    req_i = 2'b01; we_i = 2'b00; addr0_i = 10'd7;
    model_step();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL lock_pre_gnt got=%b exp=01", gnt_o); end
    next_cycle();
    req_i = 2'b11; we_i = 2'b10; lock_i = 2'b10; addr0_i = 10'd8;
    for (int i = 0; i < 64; i++) begin
      addr1_i = AW'(i); wdata1_i = {$urandom, $urandom}; lock_i[1] = (i != 63);
      model_step();
      n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL lock_burst i=%0d got=%b exp=10", i, gnt_o); end
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL lock_busy i=%0d got=%b exp=1", i, busy_o); end
      next_cycle();
    end
    we_i = 2'b00; addr1_i = 10'd3; lock_i = 2'b00;
    model_step();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL lock_release got=%b exp=01", gnt_o); end
    next_cycle();
    addr0_i = 10'd9;
    model_step();
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL lock_after got=%b exp=10", gnt_o); end
    next_cycle();
    req_i = 2'b00;
    for (int t = 0; t < int'(RL) + 3; t++) begin
      model_step();
      n_checks++;
      if (rvalid_o !== e_rv || (e_rv != 0 && rdata_o !== e_rdata)) begin
        n_fail++; $display("FAIL lock_drain t=%0d got=%b/%h exp=%b/%h", t, rvalid_o, rdata_o, e_rv, e_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    we_i = 2'b00; lock_i = 2'b00;
    for (int t = 0; t < 10; t++) begin
      req_i = (t < 4) ? 2'b01 : 2'b00;
      addr0_i = AW'(t);
      model_step();
      if (t < 4) begin
        n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt t=%0d got=%b exp=01", t, gnt_o); end
      end
      n_checks++;
      if (rvalid_o !== ((t >= 4 && t <= 7) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL b2b_rvalid t=%0d got=%b", t, rvalid_o);
      end
      if (t >= 4 && t <= 7) begin
        n_checks++;
        if (rdata_o !== m_mem[t-4]) begin n_fail++; $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, rdata_o, m_mem[t-4]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    we_i = 2'b00; lock_i = 2'b00;
    req_i = 2'b01; addr0_i = 10'd1; model_step(); next_cycle();
    req_i = 2'b10; addr1_i = 10'd2; model_step(); next_cycle();
    req_i = 2'b00; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rvalid_o !== 2'b00 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_hold got=%b/%b exp=00/0", rvalid_o, busy_o); end
    @(posedge clk);
    reset_model();
    #1 rst = 1'b1;
    for (int t = 0; t < int'(RL) + 3; t++) begin
      model_step();
      n_checks++; if (rvalid_o !== 2'b00) begin n_fail++; $display("FAIL midrst_rvalid t=%0d got=%b exp=00", t, rvalid_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy t=%0d got=%b exp=0", t, busy_o); end
      next_cycle();
    end
    req_i = 2'b11;
    model_step();
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL midrst_tie got=%b exp=01", gnt_o); end
    next_cycle();
    req_i = 2'b01;
    model_step();
    next_cycle();
    req_i = 2'b00;
    for (int t = 0; t < int'(RL) + 2; t++) begin model_step(); next_cycle(); end
  endtask

  task automatic test_random();
    logic [1:0] prev_g;
    int nr;
    nr = 400;
    prev_g = 2'b00;
    apply_reset();
    for (int t = 0; t < nr + int'(RL) + 8; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(req_i[k] && !prev_g[k])) begin
          if (t < nr) begin
            req_i[k]  = ($urandom_range(0, 3) != 0);
            we_i[k]   = 1'($urandom_range(0, 1));
            lock_i[k] = ($urandom_range(0, 3) == 0);
            if (k == 0) begin addr0_i = AW'($urandom_range(0, 15)); wdata0_i = {$urandom, $urandom}; end
            else begin addr1_i = AW'($urandom_range(0, 15)); wdata1_i = {$urandom, $urandom}; end
          end else begin
            req_i[k] = 1'b0; lock_i[k] = 1'b0;
          end
        end
      end
      model_step();
      prev_g = e_gnt;
      n_checks++; if (gnt_o !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt t=%0d got=%b exp=%b", t, gnt_o, e_gnt); end
      n_checks++; if (rvalid_o !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid t=%0d got=%b exp=%b", t, rvalid_o, e_rv); end
      if (e_rv != 2'b00) begin
        n_checks++; if (rdata_o !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, rdata_o, e_rdata); end
      end
      n_checks++; if (busy_o !== e_busy) begin n_fail++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, busy_o, e_busy); end
      n_checks++;
      if (BRAM_en !== e_en || BRAM_we !== e_we) begin
        n_fail++; $display("FAIL rnd_en_we t=%0d got=%b%b exp=%b%b", t, BRAM_en, BRAM_we, e_en, e_we);
      end
      if (e_en) begin
        n_checks++;
        if (BRAM_addr !== e_addr || (e_we && BRAM_din !== e_din)) begin
          n_fail++; $display("FAIL rnd_cmd t=%0d got=%h/%h exp=%h/%h", t, BRAM_addr, BRAM_din, e_addr, e_din);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < int'(Words); i++) begin
      v = {$urandom, $urandom};
      bram_mem[i] <= v;
      m_mem[i] = v;
    end
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
